// File: rtl/adaptive_traffic_ctrl_n_pkg.sv
// Shared lamp encodings, phase enum and popcount helper for the traffic controller.
package traffic_pkg;

  localparam logic [2:0] LIGHT_RED    = 3'b001;
  localparam logic [2:0] LIGHT_YELLOW = 3'b010;
  localparam logic [2:0] LIGHT_GREEN  = 3'b100;

  typedef enum logic [1:0] {
    PH_ALL_RED = 2'd0,
    PH_GREEN   = 2'd1,
    PH_YELLOW  = 2'd2
  } phase_e;

  // Widest sensor slice the popcount helper accepts.
  localparam int unsigned POP_MAX_W = 32;

  function automatic int unsigned popcount(input logic [POP_MAX_W-1:0] v);
    int unsigned c;
    c = 0;
    for (int i = 0; i < POP_MAX_W; i++) begin
      if (v[i]) c++;
    end
    return c;
  endfunction

endpackage

// File: rtl/adaptive_traffic_ctrl_n_if.sv
// Sensor/emergency inputs and lamp/phase outputs of the traffic controller.
interface adaptive_traffic_ctrl_n_if #(
  parameter int unsigned N_APPROACH = 4,
  parameter int unsigned SENSOR_W   = 2
);
  import traffic_pkg::*;

  localparam int unsigned AW = $clog2(N_APPROACH);

  logic [N_APPROACH*SENSOR_W-1:0] sensors;
  logic [N_APPROACH-1:0]          emerg_req;
  logic [3*N_APPROACH-1:0]        lights;
  logic [AW-1:0]                  active_idx;
  phase_e                         phase;

  modport master (output sensors, output emerg_req,
                  input lights, input active_idx, input phase);
  modport slave  (input sensors, input emerg_req,
                  output lights, output active_idx, output phase);

endinterface

// File: rtl/adaptive_traffic_ctrl_n_phase_timer.sv
// Phase down-counter: load on phase entry, decrement to zero, optional hold.
module phase_timer #(
  parameter int unsigned CNT_W   = 6,
  parameter int unsigned RST_VAL = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_hold,
  output logic             o_zero
);

  logic [CNT_W-1:0] r_cnt;

  // Load wins over hold; the count saturates at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= CNT_W'(RST_VAL);
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (!i_hold && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/adaptive_traffic_ctrl_n.sv
// N-approach adaptive traffic controller: density-scaled green, empty-approach skip,
// yellow/all-red clearance and per-approach emergency pre-emption.
module adaptive_traffic_ctrl_n
  import traffic_pkg::*;
#(
  parameter int unsigned N_APPROACH   = 4,
  parameter int unsigned SENSOR_W     = 2,
  parameter int unsigned CNT_W        = 6,
  parameter int unsigned BASE_GREEN   = 5,
  parameter int unsigned GREEN_STEP   = 5,
  parameter int unsigned MAX_GREEN    = 20,
  parameter int unsigned YELLOW_TIME  = 3,
  parameter int unsigned ALL_RED_TIME = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  adaptive_traffic_ctrl_n_if.slave   io_bus
);

  localparam int unsigned AW = $clog2(N_APPROACH);
  localparam int unsigned DW = $clog2(SENSOR_W + 1);
  localparam int unsigned PW = CNT_W + DW;

  phase_e                  r_phase;
  logic [AW-1:0]           r_idx;
  logic [3*N_APPROACH-1:0] r_lights;

  logic [DW-1:0]    w_dens [N_APPROACH];
  logic [AW-1:0]    w_next_idx, w_emerg_idx, w_rr_idx, w_sel_idx;
  logic             w_emerg_any, w_rr_found;
  logic [31:0]      w_dist, w_best;
  logic [DW-1:0]    w_sel_dens;
  logic [PW-1:0]    w_green_sum;
  logic [CNT_W-1:0] w_green_load, w_load_val;
  logic             w_own_emerg, w_other_emerg, w_go, w_hold, w_zero;

  for (genvar g = 0; g < N_APPROACH; g++) begin : g_dens
    assign w_dens[g] = DW'(popcount(POP_MAX_W'(io_bus.sensors[g*SENSOR_W +: SENSOR_W])));
  end

  function automatic logic [3*N_APPROACH-1:0] lamps(input phase_e ph, input logic [AW-1:0] idx);
    logic [3*N_APPROACH-1:0] v;
    for (int i = 0; i < N_APPROACH; i++) begin
      v[3*i +: 3] = LIGHT_RED;
      if (AW'(i) == idx) begin
        if (ph == PH_GREEN)       v[3*i +: 3] = LIGHT_GREEN;
        else if (ph == PH_YELLOW) v[3*i +: 3] = LIGHT_YELLOW;
      end
    end
    return v;
  endfunction

  // Next-approach selection: lowest emergency requester, else nearest occupied approach
  // after the current one, else simply the next approach.
  always_comb begin
    w_next_idx  = (r_idx == AW'(N_APPROACH - 1)) ? '0 : r_idx + AW'(1);
    w_emerg_any = |io_bus.emerg_req;
    w_emerg_idx = '0;
    for (int i = N_APPROACH - 1; i >= 0; i--) begin
      if (io_bus.emerg_req[i]) w_emerg_idx = AW'(i);
    end
    w_rr_idx   = w_next_idx;
    w_rr_found = 1'b0;
    w_best     = N_APPROACH;
    w_dist     = '0;
    for (int i = 0; i < N_APPROACH; i++) begin
      // Distance from the search start (active+1), wrapping modulo N.
      w_dist = (32'(i) + N_APPROACH - 1 - 32'(r_idx)) % N_APPROACH;
      if ((w_dens[i] != '0) && (w_dist < w_best)) begin
        w_best     = w_dist;
        w_rr_idx   = AW'(i);
        w_rr_found = 1'b1;
      end
    end
    w_sel_idx  = w_emerg_any ? w_emerg_idx : w_rr_idx;
    w_sel_dens = w_emerg_any ? w_dens[w_emerg_idx] : (w_rr_found ? w_dens[w_rr_idx] : '0);
    w_green_sum  = PW'(BASE_GREEN) + PW'(w_sel_dens) * PW'(GREEN_STEP);
    w_green_load = (w_green_sum > PW'(MAX_GREEN)) ? CNT_W'(MAX_GREEN - 1)
                                                 : w_green_sum[CNT_W-1:0] - CNT_W'(1);
  end

  // Phase exit conditions, emergency hold and timer reload value.
  always_comb begin
    w_own_emerg   = io_bus.emerg_req[r_idx];
    w_other_emerg = 1'b0;
    for (int i = 0; i < N_APPROACH; i++) begin
      if (io_bus.emerg_req[i] && (AW'(i) != r_idx)) w_other_emerg = 1'b1;
    end
    w_go       = 1'b0;
    w_hold     = 1'b0;
    w_load_val = CNT_W'(ALL_RED_TIME - 1);
    unique case (r_phase)
      PH_ALL_RED: begin
        w_go       = w_zero;
        w_load_val = w_green_load;
      end
      PH_GREEN: begin
        w_go       = w_other_emerg | (w_zero & ~w_own_emerg);
        w_hold     = w_own_emerg & w_zero;
        w_load_val = CNT_W'(YELLOW_TIME - 1);
      end
      PH_YELLOW: begin
        w_go = w_zero;
      end
      default: begin
        w_go = 1'b1;
      end
    endcase
  end

  phase_timer #(
    .CNT_W   (CNT_W),
    .RST_VAL (ALL_RED_TIME - 1)
  ) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_go),
    .i_load_val (w_load_val),
    .i_hold     (w_hold),
    .o_zero     (w_zero)
  );

  // Phase FSM with registered lamp, phase and active-approach outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase  <= PH_ALL_RED;
      r_idx    <= AW'(N_APPROACH - 1);
      r_lights <= lamps(PH_ALL_RED, '0);
    end else if (w_go) begin
      unique case (r_phase)
        PH_ALL_RED: begin
          r_phase  <= PH_GREEN;
          r_idx    <= w_sel_idx;
          r_lights <= lamps(PH_GREEN, w_sel_idx);
        end
        PH_GREEN: begin
          r_phase  <= PH_YELLOW;
          r_lights <= lamps(PH_YELLOW, r_idx);
        end
        default: begin
          r_phase  <= PH_ALL_RED;
          r_lights <= lamps(PH_ALL_RED, r_idx);
        end
      endcase
    end
  end

  assign io_bus.lights     = r_lights;
  assign io_bus.phase      = r_phase;
  assign io_bus.active_idx = r_idx;

endmodule

// File: tb/tb_adaptive_traffic_ctrl_n.sv
// Bench for adaptive_traffic_ctrl_n: phase-duration model plus directed scenarios.
module tb_adaptive_traffic_ctrl_n;

  localparam int N    = 4;
  localparam int SW   = 2;
  localparam int BASE = 5;
  localparam int STEP = 5;
  localparam int MAXG = 20;
  localparam int YT   = 3;
  localparam int ART  = 1;

  logic clk;
  logic rst_n;

  adaptive_traffic_ctrl_n_if #(.N_APPROACH(N), .SENSOR_W(SW)) bus ();
  adaptive_traffic_ctrl_n_if #(.N_APPROACH(N), .SENSOR_W(4))  bus4 ();

  adaptive_traffic_ctrl_n #(
    .N_APPROACH(N), .SENSOR_W(SW), .CNT_W(6), .BASE_GREEN(BASE), .GREEN_STEP(STEP),
    .MAX_GREEN(MAXG), .YELLOW_TIME(YT), .ALL_RED_TIME(ART)
  ) u_dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .io_bus (bus)
  );

  adaptive_traffic_ctrl_n #(
    .N_APPROACH(N), .SENSOR_W(4), .CNT_W(6), .BASE_GREEN(BASE), .GREEN_STEP(STEP),
    .MAX_GREEN(MAXG), .YELLOW_TIME(YT), .ALL_RED_TIME(ART)
  ) u_dut_w4 (
    .clk    (clk),
    .rst_n  (rst_n),
    .io_bus (bus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: phase (0 all-red, 1 green, 2 yellow), owner, cycles spent, phase length.
  int m_ph, m_idx, m_el, m_dur;

  function automatic int density(int j);
    return $countones(bus.sensors[j*SW +: SW]);
  endfunction

  function automatic int green_len(int j);
    int g;
    g = BASE + density(j) * STEP;
    return (g > MAXG) ? MAXG : g;
  endfunction

  function automatic int pick_idx();
    for (int j = 0; j < N; j++) if (bus.emerg_req[j]) return j;
    for (int k = 1; k <= N; k++) begin
      int j;
      j = (m_idx + k) % N;
      if (density(j) > 0) return j;
    end
    return (m_idx + 1) % N;
  endfunction

  function automatic bit others_req();
    for (int j = 0; j < N; j++) if (j != m_idx && bus.emerg_req[j]) return 1'b1;
    return 1'b0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ph <= 0; m_idx <= N - 1; m_el <= 1; m_dur <= ART;
    end else begin
      case (m_ph)
        0: if (m_el >= m_dur) begin
             m_ph <= 1; m_idx <= pick_idx(); m_el <= 1; m_dur <= green_len(pick_idx());
           end else m_el <= m_el + 1;
        1: if (others_req()) begin
             m_ph <= 2; m_el <= 1; m_dur <= YT;
           end else if (m_el >= m_dur) begin
             if (!bus.emerg_req[m_idx]) begin m_ph <= 2; m_el <= 1; m_dur <= YT; end
           end else m_el <= m_el + 1;
        default: if (m_el >= m_dur) begin
             m_ph <= 0; m_el <= 1; m_dur <= ART;
           end else m_el <= m_el + 1;
      endcase
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cmp_model();
    logic [3*N-1:0] e;
    int legal, nonred;
    for (int i = 0; i < N; i++) begin
      e[3*i +: 3] = 3'b001;
      if (i == m_idx && m_ph == 1) e[3*i +: 3] = 3'b100;
      if (i == m_idx && m_ph == 2) e[3*i +: 3] = 3'b010;
    end
    check("lights", 32'(bus.lights), 32'(e));
    check("phase", 32'(bus.phase), m_ph);
    check("active_idx", 32'(bus.active_idx), m_idx);
    legal = 1; nonred = 0;
    for (int i = 0; i < N; i++) begin
      if (!(bus.lights[3*i +: 3] inside {3'b001, 3'b010, 3'b100})) legal = 0;
      if (bus.lights[3*i +: 3] != 3'b001) nonred++;
    end
    check("lamp_onehot", legal, 1);
    check("lamp_mutex", (nonred <= 1) ? 1 : 0, 1);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      cmp_model();
    end
  endtask

  task automatic lit(input string tag, input int ph, input int idx);
    check({tag, "_phase"}, 32'(bus.phase), ph);
    check({tag, "_idx"}, 32'(bus.active_idx), idx);
  endtask

  task automatic lit4(input string tag, input int ph, input int idx);
    check({tag, "_phase"}, 32'(bus4.phase), ph);
    check({tag, "_idx"}, 32'(bus4.active_idx), idx);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.sensors = '0;   bus.emerg_req = '0;
    bus4.sensors = 16'h000F; bus4.emerg_req = '0;
    tick(2);
    lit("reset", 0, 3);
    check("reset_lights", 32'(bus.lights), 32'h249);
    lit4("w4_reset", 0, 3);
    rst_n = 1'b1;
    // Idle rotation: 5 green + 3 yellow + 1 all-red per approach.
    tick(1);  lit("rr0_green", 1, 0); lit4("w4_green", 1, 0);
    tick(4);  lit("rr0_green_last", 1, 0);
    tick(1);  lit("rr0_yellow", 2, 0);
    tick(3);  lit("rr0_allred", 0, 0);
    tick(1);  lit("rr1_green", 1, 1);
    tick(9);  lit("rr2_green", 1, 2);
    tick(1);  lit4("w4_green_cap_last", 1, 0);
    tick(1);  lit4("w4_yellow_after_20", 2, 0);
    tick(7);  lit("rr3_green", 1, 3);
    tick(9);  lit("rr0_again", 1, 0);
    // Approach 2 occupied (density 2 -> 15 cycles), 1 and 3 skipped.
    bus.sensors = 8'b0011_0000;
    tick(9);  lit("skip_to2", 1, 2);
    tick(14); lit("dens2_green_last", 1, 2);
    tick(1);  lit("dens2_yellow", 2, 2);
    tick(4);  lit("dens2_again", 1, 2);
    bus.sensors = '0;
    tick(14); lit("sampled_dens_last", 1, 2);
    tick(1);  lit("sampled_dens_yellow", 2, 2);
    tick(4);  lit("empty_next3", 1, 3);
    tick(9);  lit("back_to0", 1, 0);
    // Emergency on approach 3 during green cycle 2 of approach 0, held 30 cycles.
    tick(1);  bus.emerg_req = 4'b1000;
    tick(1);  lit("preempt_yellow", 2, 0);
    tick(3);  lit("preempt_allred", 0, 0);
    tick(1);  lit("emerg3_green", 1, 3);
    tick(25); lit("emerg3_hold", 1, 3);
    bus.emerg_req = '0;
    tick(1);  lit("emerg3_release", 2, 3);
    tick(4);  lit("after_emerg", 1, 0);
    // Simultaneous requests on 1 and 3.
    bus.emerg_req = 4'b1010;
    tick(1);  lit("dual_yellow", 2, 0);
    tick(4);  lit("dual_low_wins", 1, 1);
    bus.emerg_req = 4'b1000;
    tick(1);  lit("dual_preempt1", 2, 1);
    tick(4);  lit("dual_then3", 1, 3);
    tick(6);  lit("dual_hold3", 1, 3);
    bus.emerg_req = '0;
    tick(1);  lit("dual_release3", 2, 3);
    tick(4);  lit("own_start", 1, 0);
    // Request on the active approach during a normal green converts to hold.
    bus.emerg_req = 4'b0001;
    tick(10); lit("own_hold", 1, 0);
    bus.emerg_req = '0;
    tick(1);  lit("own_release", 2, 0);
    // Asynchronous reset in the middle of yellow.
    tick(1);  lit("pre_reset_yellow", 2, 0);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_lights", 32'(bus.lights), 32'h249);
    lit("async_rst", 0, 3);
    tick(2);
    rst_n = 1'b1;
    lit("post_rst", 0, 3);
    tick(1);  lit("post_rst_green", 1, 0);
    tick(5);  lit("post_rst_yellow", 2, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/adaptive_traffic_ctrl_n.md
# adaptive_traffic_ctrl_n

Parametrised N-approach adaptive traffic-light controller, the next generation of the 4-way controller top. It measures per-approach occupancy as the popcount of each sensor slice, scales green time to that density, skips empty approaches, and inserts yellow and all-red clearance phases. It also supports per-approach emergency pre-emption. It sits directly under the intersection top and drives the lamp-driver outputs.

## Interface
- N_APPROACH, 4, number of approaches (≥2)
- SENSOR_W, 2, sensor bits per approach; density = popcount (0..SENSOR_W)
- CNT_W, 6, phase-timer width; all durations must fit in it
- BASE_GREEN, 5, green cycles at density 0
- GREEN_STEP, 5, extra green cycles per density unit
- MAX_GREEN, 20, green cap (cycles)
- YELLOW_TIME, 3, yellow cycles
- ALL_RED_TIME, 1, all-red clearance cycles
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- sensors  in  N_APPROACH*SENSOR_W  approach i occupies bits [i*SENSOR_W +: SENSOR_W]
- emerg_req  in  N_APPROACH  level emergency request per approach
- lights  out  3*N_APPROACH  approach i at [3i +: 3]; 3'b001 red, 3'b010 yellow, 3'b100 green
- active_idx  out  $clog2(N_APPROACH)  approach currently owning green/yellow
- phase  out  2  2'd0 ALL_RED, 2'd1 GREEN, 2'd2 YELLOW

## Operation
- States: ALL_RED → GREEN → YELLOW → ALL_RED. The timer loads duration−1 on state entry and decrements every cycle; the state exits when the timer is 0 and the exit is enabled. Each phase therefore lasts exactly its duration.
- Selection happens on the last ALL_RED cycle:
  - If any emerg_req is set, the lowest-index requester wins.
  - Otherwise, round-robin from active_idx+1 (mod N): the first approach with density>0 wins.
  - If all densities are 0, active_idx+1 wins with BASE_GREEN.
- Green duration = min(BASE_GREEN + density*GREEN_STEP, MAX_GREEN).
  - Density is sampled once, at selection. Later sensor changes do not alter the loaded duration.
  - Compute the product in CNT_W+$clog2(SENSOR_W+1) bits, then saturate.
- Emergency pre-emption:
  - Trigger: during GREEN, emerg_req for any approach ≠ active_idx.
  - Response: the next cycle is YELLOW, truncating the remaining green.
- Emergency hold: while GREEN is held by an emergency approach and its emerg_req stays high, the timer holds at 0 and GREEN is extended. On deassertion the block enters YELLOW next cycle.
- Lights:
  - active_idx shows green in GREEN and yellow in YELLOW.
  - All other approaches, and every approach in ALL_RED, show red.
  - Two approaches are never non-red at once.

## Timing
- Reset values: lights all 3'b001, phase ALL_RED, active_idx = N_APPROACH−1 (so the first search starts at 0), timer = ALL_RED_TIME−1.
- Outputs are registered. lights, phase and active_idx change in the same cycle as the state register.
- Selection-to-green latency is 1 cycle: the selection registers at the ALL_RED→GREEN edge.
- emerg_req to YELLOW is 1 cycle. Minimum emergency-to-green for another approach is YELLOW_TIME + ALL_RED_TIME + 1 cycles.
- Emergency request arriving during YELLOW or ALL_RED: no truncation; it is honoured at the next selection.
- Emergency request on the active approach during normal green: it converts to hold, i.e. the green extends while the request stays high.
- Simultaneous emergency requests: lowest index wins. The others are served at later selections while still asserted.
- Reset mid-phase: all outputs return to reset values immediately (asynchronous). The first GREEN follows ALL_RED_TIME cycles after release.

## Structure
- Package traffic_pkg holds:
  - light encodings LIGHT_RED/LIGHT_YELLOW/LIGHT_GREEN
  - the phase enum PH_ALL_RED/PH_GREEN/PH_YELLOW
  - a popcount function
- Sub-module phase_timer (CNT_W load/decrement/hold, zero flag) is the parametrised successor of the existing counter.
- Selection logic and the FSM stay in the top module.

## Test plan
- Reset, all sensors 0: approaches 0,1,2,3 green in turn, 5 cycles each, each followed by 3 yellow and 1 all-red. Period 9 cycles per approach.
- sensors approach 2 = 2'b11, others 0, starting after approach 0 green: 1 and 3 are skipped; approach 2 gets 15 green cycles, then approach 2 again.
- SENSOR_W=4, density 4: green capped at 20 cycles (not 25).
- emerg_req[3] pulsed high on cycle 2 of approach 0 green: yellow on the next cycle, then all-red, then approach 3 green. If held 30 cycles, green lasts until 1 cycle after release.
- emerg_req[1] and emerg_req[3] together: approach 1 green first; approach 3 next if still asserted.
- rst_n low mid-yellow: all lights red immediately; after release the first green is approach 0 after 1 all-red cycle. Check the one-hot and mutual-exclusion assertions throughout.
